// File: rtl/ft245_pkg.sv
// Shared types and constants for the FT245 command receiver: FSM states,
// opcodes and legal parameter ranges.
package ft245_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    RECOVER = 2'd2
  } state_e;

  localparam logic [3:0] OP_TOGGLE = 4'h3;
  localparam logic [3:0] OP_SET    = 4'h4;
  localparam logic [3:0] OP_CLR    = 4'h5;
  localparam logic [7:0] OP_WRALL  = 8'h60;

  localparam int unsigned NUM_CH_MIN  = 1;
  localparam int unsigned NUM_CH_MAX  = 8;
  localparam int unsigned RD_LOW_MIN  = 2;
  localparam int unsigned RD_LOW_MAX  = 15;
  localparam int unsigned RD_HIGH_MIN = 3;
  localparam int unsigned RD_HIGH_MAX = 15;

  // Phase counter is wide enough for the largest legal strobe/recovery width.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/ft245_rxf_sync.sv
// Two-flop synchroniser for the asynchronous RXF# pin; resets to 1 so the
// receiver sees "no data" until the pin has been sampled twice.
module ft245_rxf_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/ft245_cmd_rx.sv
// FT245 asynchronous-FIFO read controller with single/two-byte command decode.
// Define FT245_CMD_RX_ERRCNT_EN to add the saturating err_count output.
module ft245_cmd_rx
  import ft245_pkg::*;
#(
  parameter int unsigned NUM_CH         = 8,
  parameter int unsigned RD_LOW_CYCLES  = 3,
  parameter int unsigned RD_HIGH_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        usb_d,
  input  logic              usb_rxfn,
  output logic              usb_rdn,
  output logic [NUM_CH-1:0] ch_out,
  output logic [7:0]        rx_byte,
  output logic              rx_valid,
  output logic              cmd_err
`ifdef FT245_CMD_RX_ERRCNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX ||
      RD_LOW_CYCLES < RD_LOW_MIN || RD_LOW_CYCLES > RD_LOW_MAX ||
      RD_HIGH_CYCLES < RD_HIGH_MIN || RD_HIGH_CYCLES > RD_HIGH_MAX) begin : g_param_err
    $error("ft245_cmd_rx: parameter out of legal range");
  end

  logic rxf_s;

  ft245_rxf_sync u_rxf_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (usb_rxfn),
    .sync_out (rxf_s)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               usb_rdn_q, usb_rdn_d;
  logic [7:0]         rx_byte_q, rx_byte_d;
  logic               rx_valid_q, rx_valid_d;
  logic [NUM_CH-1:0]  ch_q, ch_d;
  logic               pending_q, pending_d;
  logic               cmd_err_q, cmd_err_d;

  // Read strobe sequencer; usb_rdn is looked ahead from the next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxf_s) begin
          state_d = STROBE;
          cnt_d   = '0;
        end
      end
      STROBE: begin
        if (cnt_q == CNT_W'(RD_LOW_CYCLES - 1)) begin
          state_d    = RECOVER;
          cnt_d      = '0;
          rx_byte_d  = usb_d;
          rx_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RECOVER: begin
        if (cnt_q == CNT_W'(RD_HIGH_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    usb_rdn_d = (state_d != STROBE);
  end

  logic [3:0] op;
  logic [3:0] idx;
  logic       op_ok;
  logic       idx_ok;

  // Command decode, active in the rx_valid cycle; a write-all header arms
  // the pending flag so the next byte is taken as raw payload.
  always_comb begin
    ch_d      = ch_q;
    pending_d = pending_q;
    cmd_err_d = 1'b0;
    op        = rx_byte_q[7:4];
    idx       = rx_byte_q[3:0];
    op_ok     = (op == OP_TOGGLE) || (op == OP_SET) || (op == OP_CLR);
    idx_ok    = (32'(idx) < NUM_CH);
    if (rx_valid_q) begin
      if (pending_q) begin
        ch_d      = rx_byte_q[NUM_CH-1:0];
        pending_d = 1'b0;
      end else if (rx_byte_q == OP_WRALL) begin
        pending_d = 1'b1;
      end else if (op_ok && idx_ok) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (idx == 4'(i)) begin
            case (op)
              OP_TOGGLE: ch_d[i] = ~ch_q[i];
              OP_SET:    ch_d[i] = 1'b1;
              OP_CLR:    ch_d[i] = 1'b0;
              default:   ch_d[i] = ch_q[i];
            endcase
          end
        end
      end else begin
        cmd_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      usb_rdn_q  <= 1'b1;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      ch_q       <= '0;
      pending_q  <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      usb_rdn_q  <= usb_rdn_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      ch_q       <= ch_d;
      pending_q  <= pending_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign usb_rdn  = usb_rdn_q;
  assign ch_out   = ch_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign cmd_err  = cmd_err_q;

`ifdef FT245_CMD_RX_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Counts alongside the cmd_err pulse and sticks at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cmd_err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= 16'h0000;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ft245_cmd_rx.sv
// Bench for ft245_cmd_rx: an 8-channel default-timing instance and a
// 4-channel instance with 5/4 strobe timing, checked against a byte-level model.
module tb_ft245_cmd_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] d0, d1;
  logic       rxfn0, rxfn1;
  logic       rdn0, rdn1;
  logic [7:0] ch0;
  logic [3:0] ch1;
  logic [7:0] rb0, rb1;
  logic       rv0, rv1, ce0, ce1;
`ifdef FT245_CMD_RX_ERRCNT_EN
  logic [15:0] ec0, ec1;
`endif

  ft245_cmd_rx #(.NUM_CH(8), .RD_LOW_CYCLES(3), .RD_HIGH_CYCLES(3)) dut0 (
    .clk(clk), .reset(reset), .usb_d(d0), .usb_rxfn(rxfn0), .usb_rdn(rdn0),
    .ch_out(ch0), .rx_byte(rb0), .rx_valid(rv0), .cmd_err(ce0)
`ifdef FT245_CMD_RX_ERRCNT_EN
    , .err_count(ec0)
`endif
  );

  ft245_cmd_rx #(.NUM_CH(4), .RD_LOW_CYCLES(5), .RD_HIGH_CYCLES(4)) dut1 (
    .clk(clk), .reset(reset), .usb_d(d1), .usb_rxfn(rxfn1), .usb_rdn(rdn1),
    .ch_out(ch1), .rx_byte(rb1), .rx_valid(rv1), .cmd_err(ce1)
`ifdef FT245_CMD_RX_ERRCNT_EN
    , .err_count(ec1)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] m_ch [2];
  bit         m_pend [2];
  int         m_ec [2];
  int         prev_t [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte-level behaviour of the command set.
  function automatic void model_step(input int nch, inout logic [7:0] ch, inout bit pend,
                                     input logic [7:0] b, output bit err);
    int hi, n, mask;
    hi = int'(b) / 16;
    n = int'(b) % 16;
    mask = (1 << nch) - 1;
    err = 1'b0;
    if (pend) begin
      ch = 8'(int'(b) & mask);
      pend = 1'b0;
    end else if (b == 8'h60) begin
      pend = 1'b1;
    end else if (hi >= 3 && hi <= 5 && n < nch) begin
      if (hi == 3) ch = ch ^ 8'(1 << n);
      else if (hi == 4) ch = ch | 8'(1 << n);
      else ch = ch & ~8'(1 << n);
    end else begin
      err = 1'b1;
    end
  endfunction

  function automatic logic [7:0] rand_byte();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return {4'(3 + $urandom_range(0, 2)), 4'($urandom_range(0, 8))};
    if (r == 6) return 8'h60;
    return 8'($urandom);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ch[i] = 8'h00;
      m_pend[i] = 1'b0;
      m_ec[i] = 0;
    end
  endtask

  // Present one byte on a port, wait for its rx_valid, then check the decode.
  task automatic send(input int sel, input logic [7:0] b, input bit first, input bit last);
    int nch, lo, per, low;
    bit got, err;
    string s;
    nch = (sel != 0) ? 4 : 8;
    lo  = (sel != 0) ? 5 : 3;
    per = (sel != 0) ? 10 : 7;
    s = (sel != 0) ? "dut1" : "dut0";
    if (sel == 0) begin d0 = b; rxfn0 = 1'b0; end
    else          begin d1 = b; rxfn1 = 1'b0; end
    got = 1'b0;
    low = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      tick();
      if (((sel != 0) ? rdn1 : rdn0) == 1'b0) low++;
      if ((sel != 0) ? rv1 : rv0) got = 1'b1;
    end
    check({s, " rx_valid seen"}, 32'(got), 32'd1);
    if (got) begin
      check({s, " rx_byte"}, 32'((sel != 0) ? rb1 : rb0), 32'(b));
      check({s, " rdn low cycles"}, 32'(low), 32'(lo));
      if (!first) check({s, " byte period"}, 32'(cyc - prev_t[sel]), 32'(per));
      prev_t[sel] = cyc;
      if (last) begin
        if (sel == 0) rxfn0 = 1'b1;
        else          rxfn1 = 1'b1;
      end
      model_step(nch, m_ch[sel], m_pend[sel], b, err);
      if (err && m_ec[sel] < 65535) m_ec[sel]++;
      tick();
      check({s, " rx_valid single pulse"}, 32'((sel != 0) ? rv1 : rv0), 32'd0);
      check({s, " ch_out"}, (sel != 0) ? 32'(ch1) : 32'(ch0), 32'(m_ch[sel]));
      check({s, " cmd_err"}, 32'((sel != 0) ? ce1 : ce0), 32'(err));
`ifdef FT245_CMD_RX_ERRCNT_EN
      check({s, " err_count"}, (sel != 0) ? 32'(ec1) : 32'(ec0), 32'(m_ec[sel]));
`endif
    end
  endtask

  initial begin
    int edges, low, n;
    bit flag, err;
    logic [7:0] b;

    // Reset values
    reset = 1'b0;
    d0 = 8'h00; d1 = 8'h00;
    rxfn0 = 1'b1; rxfn1 = 1'b1;
    model_reset();
    repeat (3) tick();
    check("reset rdn0", 32'(rdn0), 32'd1);
    check("reset rdn1", 32'(rdn1), 32'd1);
    check("reset ch0", 32'(ch0), 32'd0);
    check("reset ch1", 32'(ch1), 32'd0);
    check("reset rx_byte", 32'(rb0), 32'd0);
    check("reset rx_valid", 32'(rv0), 32'd0);
    check("reset cmd_err", 32'(ce0), 32'd0);
`ifdef FT245_CMD_RX_ERRCNT_EN
    check("reset err_count", 32'(ec0), 32'd0);
`endif
    reset = 1'b1;
    tick();

    // First byte: RXF# fall to RD# low latency and strobe width
    d0 = 8'h31;
    rxfn0 = 1'b0;
    edges = 0;
    flag = 1'b0;
    for (int k = 0; k < 20 && !flag; k++) begin
      tick();
      edges++;
      if (rdn0 == 1'b0) flag = 1'b1;
    end
    check("rxf to rdn latency", 32'(edges), 32'd3);
    low = 0;
    flag = 1'b0;
    for (int k = 0; k < 20 && !flag; k++) begin
      tick();
      low++;
      if (rdn0 == 1'b1) flag = 1'b1;
    end
    check("first strobe width", 32'(low), 32'd3);
    check("first rx_valid", 32'(rv0), 32'd1);
    check("first rx_byte", 32'(rb0), 32'h31);
    prev_t[0] = cyc;
    rxfn0 = 1'b1;
    model_step(8, m_ch[0], m_pend[0], 8'h31, err);
    tick();
    check("first rx_valid pulse", 32'(rv0), 32'd0);
    check("first ch_out", 32'(ch0), 32'h02);
    check("first cmd_err", 32'(ce0), 32'd0);

    // Continuous set/set/clear stream
    send(0, 8'h40, 1'b1, 1'b0);
    send(0, 8'h47, 1'b0, 1'b0);
    send(0, 8'h52, 1'b0, 1'b1);

    // Write-all header and payload
    send(0, 8'h60, 1'b1, 1'b0);
    send(0, 8'hA5, 1'b0, 1'b1);
    check("write-all ch_out", 32'(ch0), 32'hA5);

    // Narrow instance: out-of-range channel and unknown opcode, then slow timing
    send(1, 8'h36, 1'b1, 1'b0);
    send(1, 8'h7F, 1'b0, 1'b0);
    send(1, 8'h41, 1'b0, 1'b1);
    check("narrow ch_out", 32'(ch1), 32'h2);
`ifdef FT245_CMD_RX_ERRCNT_EN
    check("narrow err_count", 32'(ec1), 32'd2);
`endif

    // Randomised continuous streams on both instances
    n = 24;
    for (int i = 0; i < n; i++) begin
      b = rand_byte();
      send(0, b, i == 0, i == n - 1);
    end
    for (int i = 0; i < n; i++) begin
      b = rand_byte();
      send(1, b, i == 0, i == n - 1);
    end

    // Reset during the second strobe cycle
    repeat (8) tick();
    d0 = 8'h45;
    rxfn0 = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 20 && !flag; k++) begin
      tick();
      if (rdn0 == 1'b0) flag = 1'b1;
    end
    check("pre-reset strobe start", 32'(flag), 32'd1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("reset mid-strobe rdn", 32'(rdn0), 32'd1);
    check("reset mid-strobe ch0", 32'(ch0), 32'd0);
    check("reset mid-strobe ch1", 32'(ch1), 32'd0);
    check("reset mid-strobe rx_valid", 32'(rv0), 32'd0);
    model_reset();
    rxfn0 = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rv0) flag = 1'b1;
    end
    check("no rx_valid after reset", 32'(flag), 32'd0);

    // Normal operation resumes
    send(0, 8'h42, 1'b1, 1'b1);
    check("resume ch0", 32'(ch0), 32'h04);
    send(1, 8'h43, 1'b1, 1'b1);
    check("resume ch1", 32'(ch1), 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
